// File: rtl/logic_arb_pkg.sv
// rtl/logic_arb_pkg.sv - shared op encodings and FSM state type for logic_arb
//
// Purpose : constants and types shared by the arbiter, its datapath and the bench.
// Contents: OP_AND/OP_OR/OP_XOR/OP_NOT op codes, state_t FSM state enum,
//           CNT_W completion counter width (LOGIC_ARB_CNT_EN builds).
package logic_arb_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/and8_gate.sv
// rtl/and8_gate.sv - bitwise AND gate
//
// Ports: i_a, i_b : operands
//        o_y      : i_a & i_b
module and8_gate #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_a & i_b;
endmodule

// File: rtl/logic8_unit.sv
// rtl/logic8_unit.sv - shared combinational logic unit (AND/OR/XOR/NOT A)
//
// Purpose: the one datapath shared by both requesters of logic_arb.
// Ports  : op   : operation select (OP_AND, OP_OR, OP_XOR, OP_NOT)
//          a, b : operands (b unused for OP_NOT)
//          f    : result
module logic8_unit
    import logic_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f
);

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_not;

    and8_gate #(.WIDTH(WIDTH)) u_and (.i_a(a), .i_b(b), .o_y(w_and));
    or8_gate  #(.WIDTH(WIDTH)) u_or  (.i_a(a), .i_b(b), .o_y(w_or));
    xor8_gate #(.WIDTH(WIDTH)) u_xor (.i_a(a), .i_b(b), .o_y(w_xor));
    not8_gate #(.WIDTH(WIDTH)) u_not (.i_a(a), .o_y(w_not));

    always_comb begin
        f = w_and;
        unique case (op)
            OP_AND:  f = w_and;
            OP_OR:   f = w_or;
            OP_XOR:  f = w_xor;
            OP_NOT:  f = w_not;
            default: f = w_and;
        endcase
    end

endmodule

// File: rtl/not8_gate.sv
// rtl/not8_gate.sv - bitwise NOT gate
//
// Ports: i_a : operand
//        o_y : ~i_a
module not8_gate #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = ~i_a;
endmodule

// File: rtl/or8_gate.sv
// rtl/or8_gate.sv - bitwise OR gate
//
// Ports: i_a, i_b : operands
//        o_y      : i_a | i_b
module or8_gate #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_a | i_b;
endmodule

// File: rtl/xor8_gate.sv
// rtl/xor8_gate.sv - bitwise XOR gate
//
// Ports: i_a, i_b : operands
//        o_y      : i_a ^ i_b
module xor8_gate #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_a ^ i_b;
endmodule

// File: rtl/logic_arb.sv
// rtl/logic_arb.sv - two-requester round-robin arbiter in front of one logic unit
//
// Purpose: grants one of two requesters in IDLE, registers the logic8_unit
//          result with the owner index, holds it in DONE until res_ready.
// Ports  : clk, rst_n                       : clock, async active-low reset
//          reqN_valid/ready/op/a/b (N=0,1)  : request handshake and operands
//          res_valid/ready/data/id          : result handshake, result, owner
//          cnt0, cnt1                       : completion counters per owner
//                                             (only with LOGIC_ARB_CNT_EN)
// Config : `define LOGIC_ARB_CNT_EN adds the saturating completion counters.
module logic_arb
    import logic_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id
`ifdef LOGIC_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_id;

    logic             w_grant_any;
    logic             w_grant_id;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_f;

    // Round-robin: under contention the index that did not win last time
    // gets the grant; a lone request always wins.
    always_comb begin
        w_grant_any = (r_state == ST_IDLE) && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else begin
            w_grant_id = req1_valid;
        end
        w_op = w_grant_id ? req1_op : req0_op;
        w_a  = w_grant_id ? req1_a  : req0_a;
        w_b  = w_grant_id ? req1_b  : req0_b;
    end

    logic8_unit #(.WIDTH(WIDTH)) u_unit (
        .op (w_op),
        .a  (w_a),
        .b  (w_b),
        .f  (w_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Leaving DONE never grants in the same cycle, so peak rate is 1 op / 2 cycles.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (w_grant_any) w_next_state = ST_DONE;
            ST_DONE: if (res_ready)   w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // rst_n gates the readies so they drop at once, not at the next edge.
    always_comb begin
        res_valid  = (r_state == ST_DONE);
        req0_ready = rst_n && w_grant_any && !w_grant_id;
        req1_ready = rst_n && w_grant_any &&  w_grant_id;
        res_data   = r_res_data;
        res_id     = r_res_id;
    end

    // Reset value of 1 makes requester 0 win the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_data   <= '0;
            r_res_id     <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_grant_any) begin
            r_res_data   <= w_f;
            r_res_id     <= w_grant_id;
            r_last_grant <= w_grant_id;
        end
    end

`ifdef LOGIC_ARB_CNT_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;
    logic             w_res_done;

    assign w_res_done = (r_state == ST_DONE) && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_res_done) begin
            if (!r_res_id && (r_cnt0 != {CNT_W{1'b1}})) r_cnt0 <= r_cnt0 + 1'b1;
            if ( r_res_id && (r_cnt1 != {CNT_W{1'b1}})) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_logic_arb.sv
// tb/tb_logic_arb.sv - scoreboard testbench for logic_arb
module tb_logic_arb;
    import logic_arb_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [1:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             res_valid, res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
`ifdef LOGIC_ARB_CNT_EN
    logic [7:0]       cnt0, cnt1;
`endif

    logic_arb #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id)
`ifdef LOGIC_ARB_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             id;
    } exp_t;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_pass = 0;
    logic             m_busy = 1'b0;
    logic             m_last = 1'b1;
    logic [WIDTH-1:0] m_data = '0;
    logic             m_id = 1'b0;

    function automatic logic [WIDTH-1:0] model_f(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clock: compare at the falling edge, update model, return 1 after the rising edge.
    task automatic step();
        logic e_r0, e_r1;
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            m_data = '0;
            m_id   = 1'b0;
            sb_q.delete();
            check("rst_valid",  {31'd0, res_valid},  32'd0);
            check("rst_data",   {24'd0, res_data},   32'd0);
            check("rst_id",     {31'd0, res_id},     32'd0);
            check("rst_ready0", {31'd0, req0_ready}, 32'd0);
            check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        end else begin
            e_r0 = !m_busy && req0_valid && (!req1_valid ||  m_last);
            e_r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
            check("ready0", {31'd0, req0_ready}, {31'd0, e_r0});
            check("ready1", {31'd0, req1_ready}, {31'd0, e_r1});
            check("valid",  {31'd0, res_valid},  {31'd0, m_busy});
            if (m_busy) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                    m_busy = 1'b0;
                end else begin
                    check("res_data", {24'd0, res_data}, {24'd0, sb_q[0].data});
                    check("res_id",   {31'd0, res_id},   {31'd0, sb_q[0].id});
                    if (res_ready) begin
                        e = sb_q.pop_front();
                        m_busy = 1'b0;
                    end
                end
            end else begin
                check("idle_data", {24'd0, res_data}, {24'd0, m_data});
                check("idle_id",   {31'd0, res_id},   {31'd0, m_id});
                if (e_r0 || e_r1) begin
                    e.id   = e_r1;
                    e.data = e_r1 ? model_f(req1_op, req1_a, req1_b)
                                  : model_f(req0_op, req0_a, req0_b);
                    sb_q.push_back(e);
                    m_data = e.data;
                    m_id   = e.id;
                    m_last = e_r1;
                    m_busy = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        req0_valid = 1'b1; req0_op = OP_AND; req0_a = 8'hFF; req0_b = 8'hFF;
        req1_valid = 1'b1; req1_op = OP_AND; req1_a = 8'hFF; req1_b = 8'hFF;
        res_ready  = 1'b0;
        repeat (2) step();

        // Single request, AND.
        rst_n = 1'b1;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = OP_AND; req0_a = 8'hF0; req0_b = 8'h3C;
        res_ready  = 1'b1;
        #1 check("t30_ready", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        check("t30_valid", {31'd0, res_valid}, 32'd1);
        check("t30_data",  {24'd0, res_data},  32'h30);
        check("t30_id",    {31'd0, res_id},    32'd0);
        step();

        // Contention after reset: grants must alternate starting with 0.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = OP_OR;  req0_a = 8'h0F; req0_b = 8'hF0;
        req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 8'hFF; req1_b = 8'h0F;
        res_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i % 2 == 0) begin
                check("t31_grant0", {31'd0, req0_ready}, ((i / 2) % 2 == 0) ? 32'd1 : 32'd0);
                check("t31_grant1", {31'd0, req1_ready}, ((i / 2) % 2 == 1) ? 32'd1 : 32'd0);
            end else begin
                check("t31_data", {24'd0, res_data}, ((i / 2) % 2 == 0) ? 32'hFF : 32'hF0);
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Backpressure: result held for 5 cycles with requests pending.
        req0_valid = 1'b1; req0_op = OP_XOR; req0_a = 8'h55; req0_b = 8'h0F;
        res_ready  = 1'b0;
        step();
        req1_valid = 1'b1; req1_op = OP_AND; req1_a = 8'h12; req1_b = 8'h34;
        repeat (5) step();
        check("t32_data", {24'd0, res_data}, 32'h5A);
        res_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        step();

        // NOT A on requester 1, B ignored.
        req1_valid = 1'b1; req1_op = OP_NOT; req1_a = 8'hA5; req1_b = 8'h00;
        step();
        req1_valid = 1'b0;
        check("t33_data", {24'd0, res_data}, 32'h5A);
        check("t33_id",   {31'd0, res_id},   32'd1);
        step();

        // Reset while DONE drops the result immediately.
        req1_valid = 1'b1; req1_op = OP_OR; req1_a = 8'h01; req1_b = 8'h02;
        res_ready  = 1'b0;
        step();
        check("t34_pre_valid", {31'd0, res_valid}, 32'd1);
        rst_n = 1'b0;
        #1 check("t34_valid", {31'd0, res_valid}, 32'd0);
        check("t34_data", {24'd0, res_data}, 32'd0);
        step();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = OP_AND; req0_a = 8'hC3; req0_b = 8'hFF;
        res_ready  = 1'b1;
        #1 check("t34_first_grant", {31'd0, req0_ready}, 32'd1);
        repeat (4) step();

        // Random traffic including requests dropped before a grant.
        for (int i = 0; i < 300; i++) begin
            req0_valid = 1'($urandom_range(1));
            req1_valid = 1'($urandom_range(1));
            req0_op    = 2'($urandom_range(3));
            req1_op    = 2'($urandom_range(3));
            req0_a     = 8'($urandom);
            req0_b     = 8'($urandom);
            req1_a     = 8'($urandom);
            req1_b     = 8'($urandom);
            res_ready  = ($urandom_range(3) != 0);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        repeat (2) step();
        check("sb_drain", sb_q.size(), 32'd0);

`ifdef LOGIC_ARB_CNT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("cnt_rst0", {24'd0, cnt0}, 32'd0);
        req0_valid = 1'b1; req0_op = OP_OR; req0_a = 8'h11; req0_b = 8'h22;
        res_ready  = 1'b1;
        repeat (600) step();
        req0_valid = 1'b0;
        step();
        check("cnt0_sat", {24'd0, cnt0}, 32'd255);
        check("cnt1_zero", {24'd0, cnt1}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_arb.md
LOGIC_ARB -- requirements
Module: logic_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-004 Ports req0_valid / req1_valid, input, 1 each, SHALL mean the requester presents an operation.
REQ-005 Ports req0_ready / req1_ready, output, 1 each, SHALL mean the operation is accepted this cycle.
REQ-006 Ports req0_op / req1_op, input, 2 each, SHALL select the operation: 00 AND, 01 OR, 10 XOR, 11 NOT A.
REQ-007 Ports req0_a, req0_b, req1_a and req1_b, input, WIDTH each, SHALL carry the operands.
REQ-008 Port res_valid, output, 1, SHALL mean res_data and res_id are valid.
REQ-009 Port res_ready, input, 1, SHALL mean the consumer takes the result.
REQ-010 Port res_data, output, WIDTH, SHALL carry the result.
REQ-011 Port res_id, output, 1, SHALL carry the index of the requester that owns the result.

Function
REQ-012 The block SHALL use an FSM with two states: IDLE and DONE.
- IDLE: grant, capture and compute.
- DONE: hold the result.
REQ-013 In IDLE with at least one valid request, the block SHALL grant exactly one requester.
- reqN_ready is combinational and asserts only for the granted index.
REQ-014 Arbitration SHALL be round-robin.
- A single valid request is always granted.
- If both requests are valid, the index not equal to last_grant wins.
REQ-015 On grant, the block SHALL register the shared-unit result of the granted requester's op/a/b into res_data and its index into res_id, update last_grant, and move to DONE.
REQ-016 Latency SHALL be 1 cycle: res_valid is high in the cycle after acceptance.
REQ-017 In DONE, the block SHALL hold res_valid=1 and keep res_data and res_id stable.
- Both reqN_ready are 0.
REQ-018 In DONE with res_ready=1, the block SHALL return to IDLE.
- No new grant in that same cycle.
- Peak throughput is therefore 1 operation per 2 cycles.
REQ-019 For op 11, the result SHALL be bitwise NOT of A, and B SHALL be ignored.
- All operations are bitwise, with no carries.
REQ-020 In IDLE with no valid request, the block SHALL stay in IDLE with res_valid=0 and res_data/res_id unchanged.
REQ-021 A requester SHALL be allowed to drop valid without being granted, with no side effect.
REQ-022 The block SHALL ignore res_ready when res_valid=0.

Reset
REQ-023 Asserting rst_n low SHALL immediately force:
- state=IDLE
- res_valid=0
- res_data=0
- res_id=0
- last_grant=1, so requester 0 wins the first contention
- both reqN_ready=0
REQ-024 Reset during DONE SHALL discard the pending result with no handshake.
REQ-025 Reset deassertion SHALL be used synchronously by the FSM, with the first grant possible on the first clock edge after deassertion.

Configuration
REQ-026 With macro LOGIC_ARB_CNT_EN defined, the block SHALL add per-requester completion counters.
- Output ports cnt0 and cnt1, 8 bits each, count res_valid&&res_ready handshakes per res_id.
- The counters saturate at 255.
- Reset value is 0.
REQ-027 Without LOGIC_ARB_CNT_EN, these ports and their registers SHALL be absent, with no other behavioural change.

Structure
REQ-028 The shared package logic_arb_pkg SHALL hold the following, used by both the block and the bench:
- op encoding constants OP_AND, OP_OR, OP_XOR, OP_NOT
- FSM state typedef
REQ-029 The shared datapath SHALL be one combinational sub-module, logic8_unit, with inputs op, a, b and output f.
- It is built from the existing 8-bit AND/OR/XOR/NOT gate modules plus a 4:1 select.
- The arbiter SHALL instantiate it exactly once.

Verification
REQ-030 Single request: req0 with AND, a=8'hF0, b=8'h3C -> req0_ready in cycle 0; res_valid, res_data=8'h30 and res_id=0 in cycle 1.
REQ-031 Contention after reset:
- Stimulus: both valid each cycle; req0 OR 8'h0F|8'hF0; req1 XOR 8'hFF^8'h0F; res_ready=1.
- Response: grants alternate 0,1,0,…; results 8'hFF (id 0) and 8'hF0 (id 1).
REQ-032 Backpressure: hold res_ready=0 for 5 cycles in DONE -> res_data and res_id stable, reqN_ready=0, then one result delivered on release.
REQ-033 NOT op: req1 op=11, a=8'hA5, b=8'h00 -> res_data=8'h5A, res_id=1.
REQ-034 Reset mid-operation: assert rst_n in DONE -> res_valid=0 immediately; after release, the first contention grants req0.
REQ-035 LOGIC_ARB_CNT_EN build:
- Stimulus: 300 req0 completions.
- Response: cnt0=255 (saturated), cnt1=0.
